// File: rtl/pixie_pkg.sv
// Shared definitions for the pixie display DMA path.
//   - dma_state_e : display DMA sequencer states
//   - SC_DMA      : CPU state code that marks a DMA cycle
//   - NTSC_*      : default raster geometry (cycles/line, lines/frame,
//                   first and last DMA display line)
//   - in_range    : inclusive 9-bit line range test
package pixie_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } dma_state_e;

    localparam logic [1:0] SC_DMA = 2'b10;

    localparam int NTSC_CYCLES_PER_LINE = 14;
    localparam int NTSC_LINES_PER_FRAME = 262;
    localparam int NTSC_DISPLAY_START   = 80;
    localparam int NTSC_DISPLAY_END     = 207;

    function automatic logic in_range(input logic [8:0] v,
                                      input logic [8:0] lo,
                                      input logic [8:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixie_raster_counter.sv
// Machine-cycle / scanline position counter for the pixie display.
// Shared with the video back end so both sides agree on raster position.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   tick         : one machine-cycle boundary (clk_enable && TPA)
//   cycle_num    : machine cycle within the line, 0..CYCLES_PER_LINE-1
//   line_num     : scanline, 0..LINES_PER_FRAME-1
//   line_end     : combinational, this tick wraps the cycle counter
//   frame_start  : registered one-clk pulse, line_num has just wrapped to 0
module pixie_raster_counter
    import pixie_pkg::*;
#(
    parameter int CYCLES_PER_LINE = NTSC_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic [3:0] cycle_num,
    output logic [8:0] line_num,
    output logic       line_end,
    output logic       frame_start
);

    localparam logic [3:0] CYC_LAST  = 4'(CYCLES_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);

    logic [3:0] cycle_q, cycle_d;
    logic [8:0] line_q, line_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end;

    always_comb begin
        cycle_d       = cycle_q;
        line_d        = line_q;
        line_end      = tick && (cycle_q == CYC_LAST);
        frame_end     = line_end && (line_q == LINE_LAST);
        // Registered alongside line_q so the pulse lands in the same clk
        // that line_num reads 0.
        frame_start_d = frame_end;
        if (tick) begin
            cycle_d = (cycle_q == CYC_LAST) ? 4'd0 : cycle_q + 4'd1;
        end
        if (line_end) begin
            line_d = frame_end ? 9'd0 : line_q + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q       <= 4'd0;
            line_q        <= 9'd0;
            frame_start_q <= 1'b0;
        end else begin
            cycle_q       <= cycle_d;
            line_q        <= line_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cycle_num   = cycle_q;
    assign line_num    = line_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/pixie_dma_scheduler.sv
// CDP1861-style display DMA sequencer in the CPU machine-cycle domain.
// Requests DMA-out on display lines, captures the bytes into the video
// line buffer, and drives INT / EFx timing to the CDP1802.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   clk_enable         : CPU clock enable, qualifies every bus sample
//   TPA, TPB, SC       : CPU timing pulses and state code (10 = DMA)
//   disp_on, disp_off  : display enable / disable strobes (off wins)
//   dma_data           : CPU data bus during DMA-out
//   DMAO               : DMA-out request, active low
//   INT, EFx           : interrupt request / display status flag
//   line_wr_*          : one-clk line buffer write (byte index, data)
//   line_num           : current scanline
//   frame_start        : one-clk pulse when line_num wraps to 0
//   dma_short          : one-clk pulse, line ended with bytes missing
// Optional build macro PIXIE_DMA_STATS_EN adds dma_bytes_frame: the number
// of bytes captured in the previous frame, latched at frame_start.
module pixie_dma_scheduler
    import pixie_pkg::*;
#(
    parameter int CYCLES_PER_LINE = NTSC_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
    parameter int DISPLAY_START   = NTSC_DISPLAY_START,
    parameter int DISPLAY_END     = NTSC_DISPLAY_END,
    parameter int INT_LEAD        = 2,
    parameter int EF_LEAD         = 4,
    parameter int BYTES_PER_LINE  = 8,
    parameter int DMA_FIRST_CYCLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic       TPA,
    input  logic       TPB,
    input  logic [1:0] SC,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic [7:0] dma_data,
    output logic       DMAO,
    output logic       INT,
    output logic       EFx,
    output logic       line_wr_en,
    output logic [2:0] line_wr_addr,
    output logic [7:0] line_wr_data,
    output logic [8:0] line_num,
    output logic       frame_start,
    output logic       dma_short
`ifdef PIXIE_DMA_STATS_EN
    ,
    output logic [10:0] dma_bytes_frame
`endif
);

    localparam logic [8:0] DISP_LO   = 9'(DISPLAY_START);
    localparam logic [8:0] DISP_HI   = 9'(DISPLAY_END);
    localparam logic [8:0] INT_LO    = 9'(DISPLAY_START - INT_LEAD);
    localparam logic [8:0] INT_HI    = 9'(DISPLAY_START - 1);
    localparam logic [8:0] EF_TOP_LO = 9'(DISPLAY_START - EF_LEAD);
    localparam logic [8:0] EF_BOT_LO = 9'(DISPLAY_END - EF_LEAD + 1);
    localparam logic [3:0] REQ_CYCLE = 4'(DMA_FIRST_CYCLE - 1);
    localparam logic [3:0] BYTES_CNT = 4'(BYTES_PER_LINE);

    logic       tick, cap, on_evt, off_evt, line_end;
    logic       last_byte;
    logic [3:0] cycle_num;

    dma_state_e state_q, state_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic       disp_en_q, disp_en_d;
    logic       dmao_q, dmao_d;
    logic       int_q, int_d;
    logic       efx_q, efx_d;
    logic       wr_en_q, wr_en_d;
    logic [2:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       short_q, short_d;

    assign tick    = clk_enable && TPA;
    assign cap     = clk_enable && TPB && (SC == SC_DMA);
    assign on_evt  = clk_enable && disp_on;
    assign off_evt = clk_enable && disp_off;

    pixie_raster_counter #(
        .CYCLES_PER_LINE (CYCLES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_raster (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .cycle_num   (cycle_num),
        .line_num    (line_num),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        short_d    = 1'b0;
        last_byte  = (byte_cnt_q == BYTES_CNT - 4'd1);

        disp_en_d = disp_en_q;
        if (off_evt) begin
            disp_en_d = 1'b0;
        end else if (on_evt) begin
            disp_en_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (disp_en_q) state_d = WAIT;
            end
            WAIT: begin
                // Arm one cycle early so DMAO is low for the whole of
                // the first DMA machine cycle.
                if (tick && (cycle_num == REQ_CYCLE) &&
                    in_range(line_num, DISP_LO, DISP_HI)) begin
                    state_d    = REQ;
                    byte_cnt_d = 4'd0;
                end
            end
            REQ: begin
                if (cap) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = byte_cnt_q[2:0];
                    wr_data_d  = dma_data;
                    byte_cnt_d = (byte_cnt_q == BYTES_CNT) ? byte_cnt_q
                                                           : byte_cnt_q + 4'd1;
                    if (last_byte) state_d = DONE;
                end
                // The CPU never granted the full line: give up at end of line.
                if (line_end && !(cap && last_byte)) begin
                    short_d = 1'b1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (line_end) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        // Disabling drops any partial line silently.
        if (off_evt) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            short_d = 1'b0;
        end

        dmao_d = (state_d != REQ);
        int_d  = disp_en_q && in_range(line_num, INT_LO, INT_HI);
        efx_d  = in_range(line_num, EF_TOP_LO, INT_HI) ||
                 in_range(line_num, EF_BOT_LO, DISP_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 4'd0;
            disp_en_q  <= 1'b0;
            dmao_q     <= 1'b1;
            int_q      <= 1'b0;
            efx_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 3'd0;
            wr_data_q  <= 8'd0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            disp_en_q  <= disp_en_d;
            dmao_q     <= dmao_d;
            int_q      <= int_d;
            efx_q      <= efx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            short_q    <= short_d;
        end
    end

    assign DMAO         = dmao_q;
    assign INT          = int_q;
    assign EFx          = efx_q;
    assign line_wr_en   = wr_en_q;
    assign line_wr_addr = wr_addr_q;
    assign line_wr_data = wr_data_q;
    assign dma_short    = short_q;

`ifdef PIXIE_DMA_STATS_EN
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);

    logic [10:0] bytes_cnt_q, bytes_cnt_d;
    logic [10:0] bytes_out_q, bytes_out_d;
    logic        frame_end;

    always_comb begin
        // Same event that makes frame_start pulse next clk, so the latched
        // total appears together with frame_start.
        frame_end   = line_end && (line_num == LINE_LAST);
        bytes_out_d = bytes_out_q;
        bytes_cnt_d = bytes_cnt_q + {10'd0, wr_en_d};
        if (frame_end) begin
            bytes_out_d = bytes_cnt_q;
            bytes_cnt_d = {10'd0, wr_en_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_cnt_q <= 11'd0;
            bytes_out_q <= 11'd0;
        end else begin
            bytes_cnt_q <= bytes_cnt_d;
            bytes_out_q <= bytes_out_d;
        end
    end

    assign dma_bytes_frame = bytes_out_q;
`endif

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Scoreboard bench for pixie_dma_scheduler. A CPU bus model issues machine
// cycles (TPA, TPB, SC) from its own raster model and pushes each DMA byte
// it hands over; a monitor pops and compares on every line buffer write.
// Frames: A disabled (on+off together), B full display, C short line 90,
// D disp_off after byte 4 on line 120, E reset mid-REQ on line 100.
module tb_pixie_dma_scheduler;

    logic       clk = 1'b0;
    logic       reset, clk_enable, TPA, TPB, disp_on, disp_off;
    logic [1:0] SC;
    logic [7:0] dma_data;
    logic       DMAO, INT, EFx, line_wr_en, frame_start, dma_short;
    logic [2:0] line_wr_addr;
    logic [7:0] line_wr_data;
    logic [8:0] line_num;
`ifdef PIXIE_DMA_STATS_EN
    logic [10:0] dma_bytes_frame;
`endif

    always #5 clk = ~clk;

    pixie_dma_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .TPA          (TPA),
        .TPB          (TPB),
        .SC           (SC),
        .disp_on      (disp_on),
        .disp_off     (disp_off),
        .dma_data     (dma_data),
        .DMAO         (DMAO),
        .INT          (INT),
        .EFx          (EFx),
        .line_wr_en   (line_wr_en),
        .line_wr_addr (line_wr_addr),
        .line_wr_data (line_wr_data),
        .line_num     (line_num),
        .frame_start  (frame_start),
        .dma_short    (dma_short)
`ifdef PIXIE_DMA_STATS_EN
        ,
        .dma_bytes_frame (dma_bytes_frame)
`endif
    );

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_tests = 0, n_fail = 0;

    // Bench-side raster / display model
    int  m_cyc = 0, m_line = 0, caps = 0, frame_idx = 0;
    bit  en_m = 1'b0, short_win = 1'b0, done = 1'b0;
    int  n_short = 0, fs_cnt = 0, wr_frame = 0;
    int  exp_wr[4] = '{0, 1024, 1021, 325};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (frame %0d line %0d cycle %0d)",
                     name, act, exp, frame_idx, m_line, m_cyc);
        end
    endtask

    function automatic bit in_win(input int l);
        return (l >= 80) && (l <= 207);
    endfunction

    // Monitor: scoreboard pops and pulse checks, sampled on the falling edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (line_wr_en) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0h, scoreboard empty (line %0d)",
                             line_wr_addr, line_wr_data, m_line);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", int'(line_wr_addr), int'(e.addr));
                    check("wr_data", int'(line_wr_data), int'(e.data));
                end
                wr_frame++;
            end
            if (dma_short) begin
                n_short++;
                check("dma_short_timing", 1, int'(short_win));
            end
            if (frame_start) begin
                check("frame_start_line", int'(line_num), 0);
                if (fs_cnt < 4) begin
                    check("frame_writes", wr_frame, exp_wr[fs_cnt]);
`ifdef PIXIE_DMA_STATS_EN
                    check("dma_bytes_frame", int'(dma_bytes_frame), exp_wr[fs_cnt]);
`endif
                end
                fs_cnt++;
                wr_frame = 0;
            end
        end
    end

    // One CPU machine cycle: TPA clk, TPB clk, then an idle clk carrying a
    // TPA without clk_enable that must not count as a tick.
    task automatic mcycle();
        bit exp_low, rst_now;
        int allow;
        logic [7:0] d;
        @(posedge clk); #1;
        clk_enable = 1'b1; TPA = 1'b1; TPB = 1'b0; SC = 2'b00;
        @(posedge clk); #1;
        TPA = 1'b0;
        short_win = 1'b0;
        if (m_cyc == 13) begin
            if (en_m && in_win(m_line) && caps < 8) short_win = 1'b1;
            m_cyc = 0;
            caps  = 0;
            if (m_line == 261) begin
                m_line = 0;
                frame_idx++;
            end else begin
                m_line++;
            end
        end else begin
            m_cyc++;
        end
        check("line_num", int'(line_num), m_line);
        exp_low = en_m && in_win(m_line) && (m_cyc >= 2) && (caps < 8);
        check("DMAO", int'(DMAO), int'(!exp_low));
        if (m_cyc == 5) begin
            check("INT", int'(INT), int'(en_m && (m_line == 78 || m_line == 79)));
            check("EFx", int'(EFx), int'((m_line >= 76 && m_line <= 79) ||
                                          (m_line >= 204 && m_line <= 207)));
        end
        allow   = (frame_idx == 2 && m_line == 90) ? 5 : 8;
        rst_now = (frame_idx == 4) && (m_line == 100) && (caps == 3) && exp_low;
        d        = 8'($urandom);
        dma_data = d;
        TPB      = 1'b1;
        if (exp_low && caps < allow) begin
            SC = 2'b10;
            if (!rst_now) sb_q.push_back(wr_t'{addr: 3'(caps), data: d});
            caps++;
        end else if (frame_idx == 0) begin
            SC = 2'b10;
        end else if (exp_low) begin
            SC = 2'b01;
        end else begin
            SC = 2'b00;
        end
        if (rst_now) reset = 1'b1;
        @(posedge clk); #1;
        TPB = 1'b0; SC = 2'b00;
        if (rst_now) begin
            reset = 1'b0;
            check("rst_DMAO", int'(DMAO), 1);
            check("rst_INT", int'(INT), 0);
            check("rst_line_num", int'(line_num), 0);
            check("rst_line_wr_en", int'(line_wr_en), 0);
            check("rst_dma_short", int'(dma_short), 0);
            done = 1'b1;
        end else if (frame_idx == 3 && m_line == 120 && caps == 5 && en_m) begin
            TPA = 1'b0; disp_off = 1'b1;
            @(posedge clk); #1;
            disp_off = 1'b0;
            en_m = 1'b0;
            check("DMAO_after_off", int'(DMAO), 1);
        end else begin
            TPA = 1'b1; clk_enable = 1'b0;
        end
    endtask

    task automatic pulse_on();
        clk_enable = 1'b1; TPA = 1'b0; disp_on = 1'b1;
        @(posedge clk); #1;
        disp_on = 1'b0;
        en_m = 1'b1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; clk_enable = 1'b0; TPA = 1'b0; TPB = 1'b0; SC = 2'b00;
        disp_on = 1'b0; disp_off = 1'b0; dma_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_DMAO", int'(DMAO), 1);
        check("reset_INT", int'(INT), 0);
        check("reset_EFx", int'(EFx), 0);
        check("reset_line_wr_en", int'(line_wr_en), 0);
        check("reset_line_wr_addr", int'(line_wr_addr), 0);
        check("reset_line_wr_data", int'(line_wr_data), 0);
        check("reset_line_num", int'(line_num), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_dma_short", int'(dma_short), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Frame A: on and off together, display must stay off
        clk_enable = 1'b1; disp_on = 1'b1; disp_off = 1'b1;
        @(posedge clk); #1;
        disp_on = 1'b0; disp_off = 1'b0;
        while (frame_idx < 1) mcycle();

        // Frame B: full display; a disp_off without clk_enable is ignored
        pulse_on();
        clk_enable = 1'b0; disp_off = 1'b1;
        @(posedge clk); #1;
        disp_off = 1'b0;
        while (frame_idx < 2) mcycle();

        // Frame C: short line 90.  Frame D: off after byte 4 on line 120.
        while (frame_idx < 4) mcycle();

        // Frame E: reset during the byte 3 capture on line 100
        pulse_on();
        guard = 0;
        while (!done && guard < 6000) begin
            mcycle();
            guard++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL reset_test_timeout: line %0d not reached in %0d cycles", m_line, guard);
        end
        @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("short_count", n_short, 1);
        check("frame_start_count", fs_cnt, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete (line %0d)", m_line);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixie_dma_scheduler.md
Name: pixie_dma_scheduler

Overview:
- Sequences the CDP1861-style display DMA in the CPU machine-cycle domain.
- Tracks line and machine-cycle position. Drives DMAO, INT and EFx to the CDP1802.
- Captures the 8 DMA-out bytes of each display line and writes them into the video line buffer.
- Sits between the CPU bus and the pixie video back end; it replaces the free-running DMA/INT/EF decode.

Parameters:
- CYCLES_PER_LINE, 14, machine cycles per scanline.
- LINES_PER_FRAME, 262, scanlines per frame (NTSC).
- DISPLAY_START, 80, first line that fetches DMA.
- DISPLAY_END, 207, last line that fetches DMA (128 lines).
- INT_LEAD, 2, lines before DISPLAY_START at which INT asserts.
- EF_LEAD, 4, EFx window length in lines.
- BYTES_PER_LINE, 8, DMA bytes per display line.
- DMA_FIRST_CYCLE, 2, machine cycle in which DMAO first goes low.

Ports:
- clk  in  1  video/system clock.
- reset  in  1  synchronous, active-high.
- clk_enable  in  1  CPU clock enable; all bus sampling is qualified by it.
- TPA  in  1  CPU timing pulse A; marks the machine-cycle boundary.
- TPB  in  1  CPU timing pulse B; data-valid strobe.
- SC  in  2  CPU state code; 2'b10 = DMA cycle.
- disp_on  in  1  display enable strobe (INP 1 decode).
- disp_off  in  1  display disable strobe (OUT 1 decode).
- dma_data  in  8  CPU data bus during a DMA-out cycle.
- DMAO  out  1  DMA-out request, active low.
- INT  out  1  interrupt request, active high.
- EFx  out  1  display-status flag, active high.
- line_wr_en  out  1  one-clk write pulse to the line buffer.
- line_wr_addr  out  3  byte index 0..7 within the line.
- line_wr_data  out  8  captured byte.
- line_num  out  9  current scanline, 0..LINES_PER_FRAME-1.
- frame_start  out  1  one-clk pulse when line_num wraps to 0.
- dma_short  out  1  one-clk pulse when a line ends with fewer than 8 bytes captured.

Behaviour:
- Reset values:
  - DMAO=1, INT=0, EFx=0, line_wr_en=0, line_wr_addr=0, line_wr_data=0.
  - frame_start=0, dma_short=0, line_num=0, cycle counter=0, display_enabled=0.
  - FSM=IDLE.
- Tick definition: tick = clk_enable && TPA. Only ticks advance counters.
- Cycle counter wraps 13 -> 0; on that wrap line_num increments.
- line_num wraps LINES_PER_FRAME-1 -> 0; frame_start pulses on the same clk.
- display_enabled update is qualified by clk_enable:
  - disp_on sets it; disp_off clears it.
  - Both asserted together: disp_off wins.
- Counters run whether or not the display is enabled.
- FSM:
  - IDLE: DMAO=1. Go to WAIT when display_enabled.
  - WAIT: on a tick with cycle==DMA_FIRST_CYCLE-1 and line_num in [DISPLAY_START, DISPLAY_END], go to REQ. Byte count = 0.
  - REQ: DMAO=0. Capture when clk_enable && TPB && SC==2'b10. Capture means:
    - Register dma_data.
    - Pulse line_wr_en for one clk with addr = byte count.
    - Increment byte count.
    - On the 8th capture, go to DONE; DMAO returns to 1 on the next clk.
  - REQ timeout: on the tick that wraps the cycle counter (end of line) while still in REQ, pulse dma_short, set DMAO=1, go to WAIT.
  - DONE: DMAO=1. Return to WAIT on the line wrap.
- A TPB with SC!=2'b10 while in REQ is ignored and does not count as a capture.
- disp_off from any state:
  - Next clk: FSM=IDLE, DMAO=1.
  - A partial line is abandoned without asserting dma_short.
- INT = display_enabled && line_num in [DISPLAY_START-INT_LEAD, DISPLAY_START-1]. Registered.
- EFx = line_num in [DISPLAY_START-EF_LEAD, DISPLAY_START-1] or [DISPLAY_END-EF_LEAD+1, DISPLAY_END]. Registered. Independent of display_enabled.
- Latency: all outputs are registered, one clk after the qualifying event.
- Arithmetic: line_num is 9 bits; the byte count is 4 bits internally and saturates at 8.
- Reset mid-line: all state returns to its reset value on the next clk. No line_wr_en is issued in that clk.

Optional Feature:
PIXIE_DMA_STATS_EN
- Defined: adds output dma_bytes_frame [10:0].
  - Counts captures in the current frame.
  - Latched to the output at frame_start, then the internal counter is cleared.
  - Expected value is 1024 when the display is on.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pixie_pkg holds:
  - FSM state enum (IDLE, WAIT, REQ, DONE).
  - SC_DMA = 2'b10.
  - NTSC geometry constants: 14, 262, 80, 207.
- One natural sub-module, pixie_raster_counter: the cycle/line counters plus frame_start generation. It is reused by the video back end.

Test Plan:
- Reset mid-REQ on line 100, byte 3 -> next clk DMAO=1, INT=0, line_num=0, no line_wr_en.
- disp_on, then run a full frame with SC=2'b10 on every TPB during REQ -> exactly 8 line_wr_en per line on lines 80..207, addr 0..7 in order, 1024 writes total, DMAO high outside the window.
- line_num 78 -> INT=1 at lines 78 and 79, 0 at line 80. EFx=1 at lines 76..79 and 204..207, 0 elsewhere.
- In REQ, supply only 5 DMA cycles on line 90 -> dma_short pulses once at the end-of-line tick, DMAO=1, and line 91 fetches normally.
- disp_on and disp_off in the same clk_enable cycle -> display stays disabled, DMAO remains 1 for the whole frame.
- disp_off after byte 4 on line 120 -> DMAO=1 next clk, no further writes, no dma_short. With PIXIE_DMA_STATS_EN, the next frame_start latches dma_bytes_frame = 40*8+5 for a start on line 80.
